uart_boot_loader: RTL and testbench

UART_BOOT_LOADER -- requirements
Module: uart_boot_loader

---
 rtl/uart_boot_loader.sv | 166 ++++++++++++++++
 tb/tb_uart_boot_loader.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_boot_loader.sv
// UART boot loader: sync 0xA5, word count, then big-endian 16-bit words written to BSRAM, answered with ACK/NAK.
// Define BOOT_CHECKSUM_EN to require a trailing modulo-256 checksum byte before the response.
module uart_boot_loader #(
   parameter int CLK_FRE        = 27_000_000,
   parameter int TIMEOUT_CYCLES = 2_700_000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  rx_data,
   input  logic        rx_data_valid,
   output logic        rx_data_ready,
   output logic [7:0]  tx_data,
   output logic        tx_data_valid,
   input  logic        tx_data_ready,
   output logic [10:0] mem_addr,
   output logic [15:0] mem_din,
   output logic        mem_we,
   output logic        cpu_hold,
   output logic        load_done,
   output logic        load_err
);

   // A non-positive timeout falls back to 100 ms of the system clock.
   localparam int TO_CYCLES = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES : (CLK_FRE / 10);
   localparam int TW        = (TO_CYCLES > 1) ? $clog2(TO_CYCLES + 1) : 1;
   localparam logic [TW-1:0] TO_LAST = TW'(TO_CYCLES - 1);

   localparam logic [7:0] SYNC = 8'hA5;
   localparam logic [7:0] ACK  = 8'h06;
   localparam logic [7:0] NAK  = 8'h15;

`ifdef BOOT_CHECKSUM_EN
   typedef enum logic [2:0] {IDLE, LEN, HI, LO, WRITE, RESP, CSUM} state_t;
`else
   typedef enum logic [2:0] {IDLE, LEN, HI, LO, WRITE, RESP} state_t;
`endif

   state_t        state;
   logic [8:0]    remaining;
   logic [TW-1:0] tmo;
`ifdef BOOT_CHECKSUM_EN
   logic [7:0]    checksum;
`endif

   logic rx_fire;
   logic waiting;
   logic tmo_hit;

   always_comb begin
      rx_data_ready = 1'b0;
      waiting       = 1'b0;
      case (state)
         IDLE:        rx_data_ready = 1'b1;
         LEN, HI, LO: begin
            rx_data_ready = 1'b1;
            waiting       = 1'b1;
         end
`ifdef BOOT_CHECKSUM_EN
         CSUM: begin
            rx_data_ready = 1'b1;
            waiting       = 1'b1;
         end
`endif
         default: ;
      endcase
      rx_fire = rx_data_valid && rx_data_ready;
      tmo_hit = waiting && !rx_fire && (tmo == TO_LAST);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         remaining     <= '0;
         tmo           <= '0;
`ifdef BOOT_CHECKSUM_EN
         checksum      <= '0;
`endif
         mem_addr      <= '0;
         mem_din       <= '0;
         mem_we        <= 1'b0;
         tx_data       <= '0;
         tx_data_valid <= 1'b0;
         cpu_hold      <= 1'b0;
         load_done     <= 1'b0;
         load_err      <= 1'b0;
      end else begin
         mem_we    <= 1'b0;
         load_done <= 1'b0;
         if (tmo_hit) begin
            tmo           <= '0;
            load_err      <= 1'b1;
            tx_data       <= NAK;
            tx_data_valid <= 1'b1;
            state         <= RESP;
         end else begin
            // Idle cycles in a receiving state advance the timeout; any accepted byte restarts it.
            tmo <= (waiting && !rx_fire) ? tmo + 1'b1 : '0;
            case (state)
               IDLE: if (rx_fire && rx_data == SYNC) begin
                  load_err <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
                  checksum <= '0;
`endif
                  mem_addr <= '0;
                  cpu_hold <= 1'b1;
                  state    <= LEN;
               end
               LEN: if (rx_fire) begin
                  remaining <= (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
                  state     <= HI;
               end
               HI: if (rx_fire) begin
                  mem_din[15:8] <= rx_data;
`ifdef BOOT_CHECKSUM_EN
                  checksum      <= checksum + rx_data;
`endif
                  state         <= LO;
               end
               LO: if (rx_fire) begin
                  mem_din[7:0] <= rx_data;
`ifdef BOOT_CHECKSUM_EN
                  checksum     <= checksum + rx_data;
`endif
                  mem_we       <= 1'b1;
                  state        <= WRITE;
               end
               WRITE: begin
                  mem_addr  <= mem_addr + 11'd1;
                  remaining <= remaining - 9'd1;
                  if (remaining == 9'd1) begin
`ifdef BOOT_CHECKSUM_EN
                     state <= CSUM;
`else
                     tx_data       <= ACK;
                     tx_data_valid <= 1'b1;
                     state         <= RESP;
`endif
                  end else begin
                     state <= HI;
                  end
               end
`ifdef BOOT_CHECKSUM_EN
               CSUM: if (rx_fire) begin
                  tx_data_valid <= 1'b1;
                  state         <= RESP;
                  if (rx_data == checksum) begin
                     tx_data <= ACK;
                  end else begin
                     tx_data  <= NAK;
                     load_err <= 1'b1;
                  end
               end
`endif
               RESP: if (tx_data_ready) begin
                  tx_data_valid <= 1'b0;
                  cpu_hold      <= 1'b0;
                  load_done     <= (tx_data == ACK);
                  state         <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Scoreboard bench for uart_boot_loader: expected BSRAM writes and response bytes are queued as frames are sent.
// Expectations follow the BOOT_CHECKSUM_EN setting of the build.
module tb_uart_boot_loader;

   localparam int TMO = 200;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  rx_data = '0;
   logic        rx_data_valid = 1'b0;
   logic        rx_data_ready;
   logic [7:0]  tx_data;
   logic        tx_data_valid;
   logic        tx_data_ready;
   logic [10:0] mem_addr;
   logic [15:0] mem_din;
   logic        mem_we;
   logic        cpu_hold;
   logic        load_done;
   logic        load_err;

   always #5 clk = ~clk;

   uart_boot_loader #(.CLK_FRE(27_000_000), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst_n(rst_n),
      .rx_data(rx_data), .rx_data_valid(rx_data_valid), .rx_data_ready(rx_data_ready),
      .tx_data(tx_data), .tx_data_valid(tx_data_valid), .tx_data_ready(tx_data_ready),
      .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we),
      .cpu_hold(cpu_hold), .load_done(load_done), .load_err(load_err)
   );

   int          checks = 0;
   int          errors = 0;
   int          done_cnt = 0;
   int          tx_cnt = 0;
   logic        stall_tx = 1'b0;
   logic [7:0]  exp_tx[$];
   logic [26:0] exp_we[$];

`ifdef BOOT_CHECKSUM_EN
   localparam bit CSUM_ON = 1'b1;
`else
   localparam bit CSUM_ON = 1'b0;
`endif

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   always @(negedge clk) begin : we_mon
      logic [26:0] e;
      if (rst_n && mem_we) begin
         check("we_expected", 32'(exp_we.size() != 0), 32'd1);
         if (exp_we.size() != 0) begin
            e = exp_we.pop_front();
            check("we_addr", 32'(mem_addr), 32'(e[26:16]));
            check("we_data", 32'(mem_din), 32'(e[15:0]));
         end
      end
   end

   always @(negedge clk) if (load_done) done_cnt++;

   initial begin : tx_mon
      logic [7:0] first;
      logic       stable;
      tx_data_ready = 1'b1;
      forever begin
         @(negedge clk);
         if (rst_n && tx_data_valid) begin
            if (stall_tx) begin
               tx_data_ready = 1'b0;
               first  = tx_data;
               stable = 1'b1;
               for (int i = 0; i < 50; i++) begin
                  @(negedge clk);
                  if (!tx_data_valid || tx_data !== first) stable = 1'b0;
               end
               check("tx_stall_stable", 32'(stable), 32'd1);
               stall_tx      = 1'b0;
               tx_data_ready = 1'b1;
            end
            check("tx_expected", 32'(exp_tx.size() != 0), 32'd1);
            if (exp_tx.size() != 0) check("tx_data", 32'(tx_data), 32'(exp_tx.pop_front()));
            @(posedge clk);
            tx_cnt++;
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      bit ok = 1'b0;
      @(negedge clk);
      rx_data       = b;
      rx_data_valid = 1'b1;
      for (int i = 0; i < 2000 && !ok; i++) begin
         if (rx_data_ready) begin
            @(posedge clk);
            ok = 1'b1;
         end else begin
            @(negedge clk);
         end
      end
      @(negedge clk);
      rx_data_valid = 1'b0;
      check("rx_accept", 32'(ok), 32'd1);
   endtask

   task automatic wait_resp();
      for (int i = 0; i < TMO * 4 && (exp_tx.size() != 0 || tx_data_valid); i++) @(negedge clk);
      @(negedge clk);
      check("resp_all_sent", 32'(exp_tx.size()), 32'd0);
      check("writes_all_seen", 32'(exp_we.size()), 32'd0);
      check("cpu_hold_released", 32'(cpu_hold), 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_addr"}, 32'(mem_addr), 32'd0);
      check({tag, "_din"}, 32'(mem_din), 32'd0);
      check({tag, "_we"}, 32'(mem_we), 32'd0);
      check({tag, "_tx"}, 32'(tx_data), 32'd0);
      check({tag, "_txv"}, 32'(tx_data_valid), 32'd0);
      check({tag, "_hold"}, 32'(cpu_hold), 32'd0);
      check({tag, "_done"}, 32'(load_done), 32'd0);
      check({tag, "_err"}, 32'(load_err), 32'd0);
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int d0;
      repeat (3) @(negedge clk);
      #1;
      check_reset_outputs("rst");
      check("rst_ready", 32'(rx_data_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;

      // Two-word frame; data-byte sum 12+34+AB+CD = 0x1BE -> 0xBE.
      d0 = done_cnt;
      exp_we.push_back({11'd0, 16'h1234});
      exp_we.push_back({11'd1, 16'hABCD});
      exp_tx.push_back(8'h06);
      send_byte(8'hA5);
      check("hold_after_sync", 32'(cpu_hold), 32'd1);
      send_byte(8'h02); send_byte(8'h12); send_byte(8'h34);
      send_byte(8'hAB); send_byte(8'hCD); send_byte(8'hBE);
      wait_resp();
      check("ok_done_pulses", 32'(done_cnt - d0), 32'd1);
      check("ok_err", 32'(load_err), 32'd0);

      // Bad checksum: word stays written, NAK when checksum is enabled.
      d0 = done_cnt;
      exp_we.push_back({11'd0, 16'h0001});
      exp_tx.push_back(CSUM_ON ? 8'h15 : 8'h06);
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
      send_byte(8'h01); send_byte(8'hFF);
      wait_resp();
      check("bad_err", 32'(load_err), CSUM_ON ? 32'd1 : 32'd0);
      check("bad_done", 32'(done_cnt - d0), CSUM_ON ? 32'd0 : 32'd1);

      // Stall in LO until the inter-byte timeout fires.
      d0 = done_cnt;
      exp_tx.push_back(8'h15);
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h12);
      wait_resp();
      check("tmo_err", 32'(load_err), 32'd1);
      check("tmo_done", 32'(done_cnt - d0), 32'd0);

      // Noise bytes before sync, then a held-off response handshake.
      d0 = done_cnt;
      exp_we.push_back({11'd0, 16'h0007});
      exp_tx.push_back(8'h06);
      stall_tx = 1'b1;
      send_byte(8'h55); send_byte(8'hFF);
      check("noise_no_hold", 32'(cpu_hold), 32'd0);
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
      send_byte(8'h07); send_byte(8'h07);
      wait_resp();
      check("stall_done", 32'(done_cnt - d0), 32'd1);
      check("stall_err_cleared", 32'(load_err), 32'd0);

      // Reset mid-transfer abandons it; the next frame restarts at address 0.
      d0 = tx_cnt;
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h12);
      check("pre_reset_hold", 32'(cpu_hold), 32'd1);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midrst");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      check("midrst_no_tx", 32'(tx_cnt - d0), 32'd0);
      d0 = done_cnt;
      exp_we.push_back({11'd0, 16'h0007});
      exp_tx.push_back(8'h06);
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
      send_byte(8'h07); send_byte(8'h07);
      wait_resp();
      check("restart_done", 32'(done_cnt - d0), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
